// File: rtl/rsv_alloc_ctrl_module_if.sv
// Dispatch/issue bundle of the reservation-station allocator.
// master drives requests and issues; slave returns grants and free indices.
interface rsv_alloc_ctrl_module_if #(
   parameter int RSV_IDX_WIDTH = 6,
   parameter int ISS_PORTS     = 2
);
   logic [3:0]                         i_dsp_req_vld;
   logic                               o_dsp_rdy;
   logic [3:0]                         o_dsp_rsv_vld;
   logic [RSV_IDX_WIDTH-1:0]           o_free_entry_0;
   logic [RSV_IDX_WIDTH-1:0]           o_free_entry_1;
   logic [RSV_IDX_WIDTH-1:0]           o_free_entry_2;
   logic [RSV_IDX_WIDTH-1:0]           o_free_entry_3;
   logic [ISS_PORTS-1:0]               i_iss_vld;
   logic [ISS_PORTS*RSV_IDX_WIDTH-1:0] i_iss_entry;

   modport master (
      output i_dsp_req_vld, i_iss_vld, i_iss_entry,
      input  o_dsp_rdy, o_dsp_rsv_vld,
      input  o_free_entry_0, o_free_entry_1,
      input  o_free_entry_2, o_free_entry_3
   );

   modport slave (
      input  i_dsp_req_vld, i_iss_vld, i_iss_entry,
      output o_dsp_rdy, o_dsp_rsv_vld,
      output o_free_entry_0, o_free_entry_1,
      output o_free_entry_2, o_free_entry_3
   );
endinterface

// File: rtl/rsv_alloc_ctrl_module.sv
// Reservation-station entry allocator: picks 4 lowest free entries, retires on issue.
// Optional RSV_ALLOC_CHK_EN adds a sticky o_alloc_err protocol checker.
module rsv_alloc_ctrl_module #(
   parameter int RSV_ENTRY_NUMS = 64,
   parameter int RSV_IDX_WIDTH  = 6,
   parameter int ISS_PORTS      = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_csr_trap_flush,
   input  logic                      i_exu_mis_flush,
   input  logic                      i_exu_ls_flush,
   rsv_alloc_ctrl_module_if.slave    dsp_if,
   output logic [RSV_ENTRY_NUMS-1:0] o_rsv_entry_vld_vec,
`ifdef RSV_ALLOC_CHK_EN
   output logic                      o_alloc_err,
`endif
   output logic [RSV_IDX_WIDTH:0]    o_free_cnt
);
   localparam int W = RSV_IDX_WIDTH;
   localparam int N = RSV_ENTRY_NUMS;

   logic [N-1:0]      vld_vec_q, vld_vec_d;
   logic [W:0]        free_cnt_q, free_cnt_d;
   logic              flush;
   logic              rdy;
   logic [3:0]        dsp_vld;
   logic [3:0][W-1:0] fe;
   logic [N-1:0]      set_mask;
   logic [N-1:0]      clr_req;
   logic [N-1:0]      cleared;
   logic [W:0]        cnt_set;
   logic [W:0]        cnt_clr;

   assign flush   = i_csr_trap_flush | i_exu_mis_flush | i_exu_ls_flush;
   assign rdy     = (free_cnt_q >= (W+1)'(4));
   assign dsp_vld = dsp_if.i_dsp_req_vld & {4{rdy}} & {4{~flush}};

   // Priority scan: first four zero bits of the valid vector, lowest first.
   always_comb begin
      int n;
      fe = '0;
      n  = 0;
      for (int i = 0; i < N; i++) begin
         if (!vld_vec_q[i] && n < 4) begin
            fe[n[1:0]] = W'(i);
            n = n + 1;
         end
      end
   end

   always_comb begin
      set_mask = '0;
      cnt_set  = '0;
      for (int k = 0; k < 4; k++) begin
         if (dsp_vld[k]) begin
            set_mask[fe[k]] = 1'b1;
            cnt_set = cnt_set + (W+1)'(1);
         end
      end
   end

   // Duplicate issue indices collapse into one bit, so they count once.
   always_comb begin
      clr_req = '0;
      for (int p = 0; p < ISS_PORTS; p++) begin
         if (dsp_if.i_iss_vld[p])
            clr_req[dsp_if.i_iss_entry[p*W +: W]] = 1'b1;
      end
   end

   assign cleared = clr_req & vld_vec_q;

   always_comb begin
      cnt_clr = '0;
      for (int i = 0; i < N; i++)
         cnt_clr = cnt_clr + (W+1)'(cleared[i]);
   end

   always_comb begin
      vld_vec_d  = (vld_vec_q & ~cleared) | set_mask;
      free_cnt_d = free_cnt_q - cnt_set + cnt_clr;
      if (flush) begin
         vld_vec_d  = '0;
         free_cnt_d = (W+1)'(N);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_vec_q  <= '0;
         free_cnt_q <= (W+1)'(N);
      end else begin
         vld_vec_q  <= vld_vec_d;
         free_cnt_q <= free_cnt_d;
      end
   end

`ifdef RSV_ALLOC_CHK_EN
   logic alloc_err_q, alloc_err_d;
   logic bad_evt;

   always_comb begin
      bad_evt = (|dsp_if.i_dsp_req_vld) & ~rdy;
      for (int p = 0; p < ISS_PORTS; p++) begin
         if (dsp_if.i_iss_vld[p] &&
             !vld_vec_q[dsp_if.i_iss_entry[p*W +: W]])
            bad_evt = 1'b1;
         for (int q = p + 1; q < ISS_PORTS; q++) begin
            if (dsp_if.i_iss_vld[p] && dsp_if.i_iss_vld[q] &&
                dsp_if.i_iss_entry[p*W +: W] == dsp_if.i_iss_entry[q*W +: W])
               bad_evt = 1'b1;
         end
      end
      alloc_err_d = alloc_err_q | bad_evt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alloc_err_q <= 1'b0;
      else        alloc_err_q <= alloc_err_d;
   end

   assign o_alloc_err = alloc_err_q;
`endif

   assign dsp_if.o_dsp_rdy      = rdy;
   assign dsp_if.o_dsp_rsv_vld  = dsp_vld;
   assign dsp_if.o_free_entry_0 = fe[0];
   assign dsp_if.o_free_entry_1 = fe[1];
   assign dsp_if.o_free_entry_2 = fe[2];
   assign dsp_if.o_free_entry_3 = fe[3];
   assign o_rsv_entry_vld_vec   = vld_vec_q;
   assign o_free_cnt            = free_cnt_q;
endmodule

// File: tb/tb_rsv_alloc_ctrl_module.sv
// Randomized + directed bench for rsv_alloc_ctrl_module against an entry-array model.
// Build with +define+RSV_ALLOC_CHK_EN to also check o_alloc_err.
module tb_rsv_alloc_ctrl_module;
   localparam int N = 64;
   localparam int W = 6;
   localparam int P = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic trap_fl = 1'b0;
   logic mis_fl = 1'b0;
   logic ls_fl = 1'b0;
   logic [N-1:0] vld_vec;
   logic [W:0] free_cnt;
`ifdef RSV_ALLOC_CHK_EN
   logic alloc_err;
   bit   m_err;
`endif

   int checks = 0;
   int failures = 0;

   bit m_vld[N];

   rsv_alloc_ctrl_module_if #(.RSV_IDX_WIDTH(W), .ISS_PORTS(P)) dif ();

   rsv_alloc_ctrl_module #(
      .RSV_ENTRY_NUMS(N), .RSV_IDX_WIDTH(W), .ISS_PORTS(P)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_csr_trap_flush(trap_fl),
      .i_exu_mis_flush(mis_fl),
      .i_exu_ls_flush(ls_fl),
      .dsp_if(dif.slave),
      .o_rsv_entry_vld_vec(vld_vec),
`ifdef RSV_ALLOC_CHK_EN
      .o_alloc_err(alloc_err),
`endif
      .o_free_cnt(free_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle: drive at negedge, check combinational + registered
   // outputs against the model, then advance the model at posedge.
   task automatic step(input logic [3:0] req, input logic [1:0] iv,
                       input int e0, input int e1, input logic [2:0] fl);
      int free_list[$];
      logic [63:0] exp_vec;
      logic [3:0] exp_dv;
      bit rdy, any_fl;
      dif.i_dsp_req_vld = req;
      dif.i_iss_vld = iv;
      dif.i_iss_entry = {W'(e1), W'(e0)};
      {trap_fl, mis_fl, ls_fl} = fl;
      #1;
      exp_vec = '0;
      for (int i = 0; i < N; i++) begin
         exp_vec[i] = m_vld[i];
         if (!m_vld[i]) free_list.push_back(i);
      end
      rdy = free_list.size() >= 4;
      any_fl = |fl;
      exp_dv = (rdy && !any_fl) ? req : 4'b0;
      chk("vld_vec", vld_vec, exp_vec);
      chk("free_cnt", 64'(free_cnt), 64'(free_list.size()));
      chk("dsp_rdy", 64'(dif.o_dsp_rdy), 64'(rdy));
      chk("dsp_rsv_vld", 64'(dif.o_dsp_rsv_vld), 64'(exp_dv));
      if (free_list.size() > 0) chk("free_e0", 64'(dif.o_free_entry_0), 64'(free_list[0]));
      if (free_list.size() > 1) chk("free_e1", 64'(dif.o_free_entry_1), 64'(free_list[1]));
      if (free_list.size() > 2) chk("free_e2", 64'(dif.o_free_entry_2), 64'(free_list[2]));
      if (free_list.size() > 3) chk("free_e3", 64'(dif.o_free_entry_3), 64'(free_list[3]));
`ifdef RSV_ALLOC_CHK_EN
      chk("alloc_err", 64'(alloc_err), 64'(m_err));
      if ((req != 0 && !rdy) || (iv[0] && !m_vld[e0]) ||
          (iv[1] && !m_vld[e1]) || (iv == 2'b11 && e0 == e1))
         m_err = 1'b1;
`endif
      if (any_fl) begin
         foreach (m_vld[i]) m_vld[i] = 1'b0;
      end else begin
         if (iv[0]) m_vld[e0] = 1'b0;
         if (iv[1]) m_vld[e1] = 1'b0;
         for (int k = 0; k < 4; k++)
            if (exp_dv[k]) m_vld[free_list[k]] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int e0, e1;
      logic [1:0] iv;
      logic [2:0] fl;
      foreach (m_vld[i]) m_vld[i] = 1'b0;
`ifdef RSV_ALLOC_CHK_EN
      m_err = 1'b0;
`endif
      dif.i_dsp_req_vld = '0;
      dif.i_iss_vld = '0;
      dif.i_iss_entry = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      step(4'b0000, 2'b00, 0, 0, 3'b000);
      for (int c = 0; c < 16; c++) step(4'b1111, 2'b00, 0, 0, 3'b000);
      step(4'b1111, 2'b00, 0, 0, 3'b000);
      step(4'b0000, 2'b11, 5, 40, 3'b000);
      step(4'b0000, 2'b00, 0, 0, 3'b000);
      step(4'b0000, 2'b00, 0, 0, 3'b100);
      step(4'b1111, 2'b00, 0, 0, 3'b000);
      step(4'b1111, 2'b00, 0, 0, 3'b000);
      step(4'b0101, 2'b00, 0, 0, 3'b000);
      step(4'b0000, 2'b00, 0, 0, 3'b000);
      step(4'b1111, 2'b01, 3, 0, 3'b010);
      step(4'b0000, 2'b00, 0, 0, 3'b000);
      step(4'b0000, 2'b01, 17, 0, 3'b000);
      step(4'b0000, 2'b00, 0, 0, 3'b001);
      step(4'b0000, 2'b00, 0, 0, 3'b000);

      for (int c = 0; c < 3000; c++) begin
         e0 = $urandom_range(0, N - 1);
         e1 = ($urandom_range(0, 7) == 0) ? e0 : $urandom_range(0, N - 1);
         iv[0] = $urandom_range(0, 9) < 8;
         iv[1] = $urandom_range(0, 9) < 7;
         fl = 3'b000;
         if ($urandom_range(0, 79) == 0) fl[$urandom_range(0, 2)] = 1'b1;
         step(4'($urandom), iv, e0, e1, fl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
